// File: rtl/cdc_pkg.sv
// Shared definitions for the clock-domain-crossing pulse path: pacer state
// encoding and a width helper for down-counters that must hold a cycle count.
package cdc_pkg;

  localparam logic [1:0] PACER_IDLE  = 2'd0;
  localparam logic [1:0] PACER_PULSE = 2'd1;
  localparam logic [1:0] PACER_GAP   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = PACER_IDLE,
    ST_PULSE = PACER_PULSE,
    ST_GAP   = PACER_GAP
  } pacer_state_e;

  // Bits needed to hold any value 0..gap_cycles; never less than one bit.
  function automatic int gap_cnt_width(input int gap_cycles);
    return (gap_cycles < 1) ? 1 : $clog2(gap_cycles + 1);
  endfunction

endpackage

// File: rtl/fast_pulse_pacer_if.sv
// Request/status bundle between a requester and the fast-domain pulse pacer.
interface fast_pulse_pacer_if #(
  parameter int CNT_W = 4
) ();

  logic             req_in;
  logic             clr_ovf;
  logic             read_out;
  logic [CNT_W-1:0] pending;
  logic             overflow;
  logic             idle;

  modport master (
    output req_in, clr_ovf,
    input  read_out, pending, overflow, idle
  );

  modport slave (
    input  req_in, clr_ovf,
    output read_out, pending, overflow, idle
  );

endinterface

// File: rtl/sat_updown_cnt.sv
// Saturating up/down counter with a sticky overflow flag. An increment at full
// scale without a simultaneous decrement is dropped and latches overflow.
module sat_updown_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr_ovf,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic drop;

  assign drop = inc && !dec && (count == CNT_MAX);

  // Counter: inc and dec together cancel; clamp at both ends.
  // NOTE: every register written in always_ff uses <= so all state updates
  // see the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && !dec && (count != CNT_MAX)) begin
      count <= count + CNT_ONE;
    end else if (dec && !inc && (count != '0)) begin
      count <= count - CNT_ONE;
    end
  end

  // Sticky overflow: a drop on the same edge as a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/fast_pulse_pacer.sv
// Fast-domain pacer ahead of a fast-to-slow pulse synchronizer. Request strobes
// are queued and re-emitted as PULSE_W-wide pulses whose rising edges are at
// least GAP_CYCLES apart, so the slow side never sees two pulses merge.
module fast_pulse_pacer
  import cdc_pkg::*;
#(
  parameter int GAP_CYCLES = 6,
  parameter int PULSE_W    = 1,
  parameter int CNT_W      = 4
) (
  input  logic               clk1,
  input  logic               sys_rst_n,
  fast_pulse_pacer_if.slave  bus
);

  localparam int               GAP_W      = gap_cnt_width(GAP_CYCLES);
  // Counter reload values: the counter runs down to zero, so load length-1.
  localparam logic [GAP_W-1:0] PULSE_LOAD = GAP_W'(PULSE_W - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD   = GAP_W'(GAP_CYCLES - PULSE_W - 1);
  localparam logic [GAP_W-1:0] GAP_ONE    = GAP_W'(1);

  pacer_state_e     state;
  logic [GAP_W-1:0] gap_cnt;
  logic             read_q;
  logic [CNT_W-1:0] pending;
  logic             overflow;

  logic avail;
  logic gap_done;
  logic launch;
  logic queue_launch;
  logic cnt_inc;

  // A launch takes a queued request first; only an empty queue lets the live
  // strobe launch directly. Strobes arriving mid-pulse/gap are always queued.
  assign avail        = (pending != '0) || bus.req_in;
  assign gap_done     = (gap_cnt == '0);
  assign launch       = avail && ((state == ST_IDLE) || ((state == ST_GAP) && gap_done));
  assign queue_launch = launch && (pending != '0);
  assign cnt_inc      = bus.req_in && !(launch && (pending == '0));

  // Pacing FSM with its shared down-counter; read_out is registered here.
  always_ff @(posedge clk1 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= ST_IDLE;
      gap_cnt <= '0;
      read_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (launch) begin
            state   <= ST_PULSE;
            gap_cnt <= PULSE_LOAD;
            read_q  <= 1'b1;
          end
        end
        ST_PULSE: begin
          if (gap_done) begin
            state   <= ST_GAP;
            gap_cnt <= GAP_LOAD;
            read_q  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - GAP_ONE;
          end
        end
        ST_GAP: begin
          if (gap_done) begin
            if (launch) begin
              state   <= ST_PULSE;
              gap_cnt <= PULSE_LOAD;
              read_q  <= 1'b1;
            end else begin
              state   <= ST_IDLE;
              gap_cnt <= '0;
            end
          end else begin
            gap_cnt <= gap_cnt - GAP_ONE;
          end
        end
        default: begin
          state   <= ST_IDLE;
          gap_cnt <= '0;
          read_q  <= 1'b0;
        end
      endcase
    end
  end

  sat_updown_cnt #(
    .CNT_W (CNT_W)
  ) u_pending (
    .clk      (clk1),
    .rst_n    (sys_rst_n),
    .inc      (cnt_inc),
    .dec      (queue_launch),
    .clr_ovf  (bus.clr_ovf),
    .count    (pending),
    .overflow (overflow)
  );

  assign bus.read_out = read_q;
  assign bus.pending  = pending;
  assign bus.overflow = overflow;
  assign bus.idle     = (state == ST_IDLE) && (pending == '0);

endmodule

// File: tb/tb_fast_pulse_pacer.sv
// Directed bench for fast_pulse_pacer: dut_a uses CNT_W=4, dut_b uses CNT_W=2
// for saturation and overflow scenarios. Both share clock and reset.
module tb_fast_pulse_pacer;

  logic clk1      = 1'b0;
  logic sys_rst_n = 1'b0;
  int   total     = 0;
  int   bad       = 0;

  fast_pulse_pacer_if #(.CNT_W(4)) ifa ();
  fast_pulse_pacer_if #(.CNT_W(2)) ifb ();

  fast_pulse_pacer #(.GAP_CYCLES(6), .PULSE_W(1), .CNT_W(4)) u_dut_a (
    .clk1      (clk1),
    .sys_rst_n (sys_rst_n),
    .bus       (ifa)
  );

  fast_pulse_pacer #(.GAP_CYCLES(6), .PULSE_W(1), .CNT_W(2)) u_dut_b (
    .clk1      (clk1),
    .sys_rst_n (sys_rst_n),
    .bus       (ifb)
  );

  always #10 clk1 = ~clk1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drive inputs at the falling edge, let one rising edge happen, then settle.
  task automatic step(input logic ra, input logic ca, input logic rb, input logic cb);
    @(negedge clk1);
    ifa.req_in  = ra;
    ifa.clr_ovf = ca;
    ifb.req_in  = rb;
    ifb.clr_ovf = cb;
    @(posedge clk1);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk1);
      total++; if (ifa.read_out !== 1'b0) begin bad++; $display("FAIL rst_read_out cyc %0d: got %b want 0", i, ifa.read_out); end
      total++; if (ifa.pending !== 4'd0) begin bad++; $display("FAIL rst_pending cyc %0d: got %0d want 0", i, ifa.pending); end
      total++; if (ifa.overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow cyc %0d: got %b want 0", i, ifa.overflow); end
      total++; if (ifa.idle !== 1'b1) begin bad++; $display("FAIL rst_idle cyc %0d: got %b want 1", i, ifa.idle); end
    end
    sys_rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      total++; if (ifa.read_out !== 1'b0) begin bad++; $display("FAIL post_rst_read_out edge %0d: got %b want 0", i, ifa.read_out); end
      total++; if (ifa.idle !== 1'b1) begin bad++; $display("FAIL post_rst_idle edge %0d: got %b want 1", i, ifa.idle); end
      total++; if (ifb.idle !== 1'b1) begin bad++; $display("FAIL post_rst_idle_b edge %0d: got %b want 1", i, ifb.idle); end
    end
  endtask

  task automatic test_single();
    logic exp_ro;
    logic exp_idle;
    for (int i = 0; i < 10; i++) begin
      step(i == 0, 1'b0, 1'b0, 1'b0);
      exp_ro   = (i == 0);
      exp_idle = (i >= 6);
      total++; if (ifa.read_out !== exp_ro) begin bad++; $display("FAIL single_read_out edge %0d: got %b want %b", i, ifa.read_out, exp_ro); end
      total++; if (ifa.pending !== 4'd0) begin bad++; $display("FAIL single_pending edge %0d: got %0d want 0", i, ifa.pending); end
      total++; if (ifa.idle !== exp_idle) begin bad++; $display("FAIL single_idle edge %0d: got %b want %b", i, ifa.idle, exp_idle); end
    end
  endtask

  task automatic test_back_to_back();
    logic       exp_ro;
    logic [3:0] exp_p;
    for (int i = 0; i < 20; i++) begin
      step(i < 3, 1'b0, 1'b0, 1'b0);
      exp_ro = (i == 0) || (i == 6) || (i == 12);
      if (i == 0)       exp_p = 4'd0;
      else if (i == 1)  exp_p = 4'd1;
      else if (i <= 5)  exp_p = 4'd2;
      else if (i <= 11) exp_p = 4'd1;
      else              exp_p = 4'd0;
      total++; if (ifa.read_out !== exp_ro) begin bad++; $display("FAIL b2b_read_out edge %0d: got %b want %b", i, ifa.read_out, exp_ro); end
      total++; if (ifa.pending !== exp_p) begin bad++; $display("FAIL b2b_pending edge %0d: got %0d want %0d", i, ifa.pending, exp_p); end
      total++; if (ifa.idle !== (i >= 18)) begin bad++; $display("FAIL b2b_idle edge %0d: got %b want %b", i, ifa.idle, (i >= 18)); end
    end
  endtask

  task automatic test_saturate();
    logic       exp_ro;
    logic [1:0] exp_p;
    int         pulses = 0;
    for (int i = 0; i < 26; i++) begin
      step(1'b0, 1'b0, i < 5, 1'b0);
      exp_ro = (i == 0) || (i == 6) || (i == 12) || (i == 18);
      if (i == 0)       exp_p = 2'd0;
      else if (i == 1)  exp_p = 2'd1;
      else if (i == 2)  exp_p = 2'd2;
      else if (i <= 5)  exp_p = 2'd3;
      else if (i <= 11) exp_p = 2'd2;
      else if (i <= 17) exp_p = 2'd1;
      else              exp_p = 2'd0;
      if (ifb.read_out === 1'b1) pulses++;
      total++; if (ifb.read_out !== exp_ro) begin bad++; $display("FAIL sat_read_out edge %0d: got %b want %b", i, ifb.read_out, exp_ro); end
      total++; if (ifb.pending !== exp_p) begin bad++; $display("FAIL sat_pending edge %0d: got %0d want %0d", i, ifb.pending, exp_p); end
      total++; if (ifb.overflow !== (i >= 4)) begin bad++; $display("FAIL sat_overflow edge %0d: got %b want %b", i, ifb.overflow, (i >= 4)); end
    end
    total++; if (pulses != 4) begin bad++; $display("FAIL sat_pulse_count: got %0d want 4", pulses); end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    total++; if (ifb.overflow !== 1'b0) begin bad++; $display("FAIL sat_clear: got %b want 0", ifb.overflow); end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (ifb.overflow !== 1'b0) begin bad++; $display("FAIL sat_clear_hold: got %b want 0", ifb.overflow); end
  endtask

  task automatic test_set_wins();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b1, i == 4);
      if (i == 3) begin
        total++; if (ifb.overflow !== 1'b0) begin bad++; $display("FAIL setwins_pre: got %b want 0", ifb.overflow); end
        total++; if (ifb.pending !== 2'd3) begin bad++; $display("FAIL setwins_full: got %0d want 3", ifb.pending); end
      end
    end
    total++; if (ifb.overflow !== 1'b1) begin bad++; $display("FAIL setwins_overflow: got %b want 1", ifb.overflow); end
    total++; if (ifb.pending !== 2'd3) begin bad++; $display("FAIL setwins_pending: got %0d want 3", ifb.pending); end
    for (int i = 0; i < 25; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (ifb.overflow !== 1'b1) begin bad++; $display("FAIL setwins_sticky: got %b want 1", ifb.overflow); end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    total++; if (ifb.overflow !== 1'b0) begin bad++; $display("FAIL setwins_clear: got %b want 0", ifb.overflow); end
    total++; if (ifb.idle !== 1'b1) begin bad++; $display("FAIL setwins_idle: got %b want 1", ifb.idle); end
  endtask

  task automatic test_coincident();
    logic       exp_ro;
    logic [3:0] exp_p;
    for (int i = 0; i < 20; i++) begin
      step((i == 0) || (i == 1) || (i == 6), 1'b0, 1'b0, 1'b0);
      exp_ro = (i == 0) || (i == 6) || (i == 12);
      exp_p  = ((i >= 1) && (i <= 11)) ? 4'd1 : 4'd0;
      total++; if (ifa.read_out !== exp_ro) begin bad++; $display("FAIL coinc_read_out edge %0d: got %b want %b", i, ifa.read_out, exp_ro); end
      total++; if (ifa.pending !== exp_p) begin bad++; $display("FAIL coinc_pending edge %0d: got %0d want %0d", i, ifa.pending, exp_p); end
      total++; if (ifa.idle !== (i >= 18)) begin bad++; $display("FAIL coinc_idle edge %0d: got %b want %b", i, ifa.idle, (i >= 18)); end
    end
  endtask

  task automatic test_reset_mid_gap();
    for (int i = 0; i < 6; i++) step(i < 3, 1'b0, i < 5, 1'b0);
    total++; if (ifa.pending !== 4'd2) begin bad++; $display("FAIL rmg_pre_pending: got %0d want 2", ifa.pending); end
    total++; if (ifb.overflow !== 1'b1) begin bad++; $display("FAIL rmg_pre_overflow: got %b want 1", ifb.overflow); end
    total++; if (ifa.idle !== 1'b0) begin bad++; $display("FAIL rmg_pre_idle: got %b want 0", ifa.idle); end
    #4;
    sys_rst_n = 1'b0;
    #1;
    total++; if (ifa.read_out !== 1'b0) begin bad++; $display("FAIL rmg_read_out: got %b want 0", ifa.read_out); end
    total++; if (ifa.pending !== 4'd0) begin bad++; $display("FAIL rmg_pending: got %0d want 0", ifa.pending); end
    total++; if (ifb.pending !== 2'd0) begin bad++; $display("FAIL rmg_pending_b: got %0d want 0", ifb.pending); end
    total++; if (ifb.overflow !== 1'b0) begin bad++; $display("FAIL rmg_overflow_b: got %b want 0", ifb.overflow); end
    total++; if (ifa.idle !== 1'b1) begin bad++; $display("FAIL rmg_idle: got %b want 1", ifa.idle); end
    ifa.req_in = 1'b0;
    ifb.req_in = 1'b0;
    repeat (3) @(posedge clk1);
    @(negedge clk1);
    sys_rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      total++; if (ifa.read_out !== 1'b0) begin bad++; $display("FAIL rmg_quiet_read_out edge %0d: got %b want 0", i, ifa.read_out); end
      total++; if (ifb.read_out !== 1'b0) begin bad++; $display("FAIL rmg_quiet_read_out_b edge %0d: got %b want 0", i, ifb.read_out); end
      total++; if (ifa.idle !== 1'b1) begin bad++; $display("FAIL rmg_quiet_idle edge %0d: got %b want 1", i, ifa.idle); end
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    total++; if (ifa.read_out !== 1'b1) begin bad++; $display("FAIL rmg_new_req: got %b want 1", ifa.read_out); end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    total++; if (ifa.read_out !== 1'b0) begin bad++; $display("FAIL rmg_new_req_end: got %b want 0", ifa.read_out); end
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    ifa.req_in  = 1'b0;
    ifa.clr_ovf = 1'b0;
    ifb.req_in  = 1'b0;
    ifb.clr_ovf = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_saturate();
    test_set_wins();
    test_coincident();
    test_reset_mid_gap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
